// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose:
//   Arbitrates two write requesters (r0 = main datapath, r1 = multi-cycle
//   unit) onto the single register-file write port.  A one-entry holding
//   register sits between the requesters and the register file.  A request
//   accepted at edge N is written on rf_we during the cycle after N.  If the
//   register file is free, the entry drains and a new request refills it in
//   the same cycle, so throughput is one write per cycle.
//   Requests to register 0 are accepted and dropped.
//
// Configuration macro:
//   RR_ARB_EN - when defined, contention is resolved round-robin.  When it is
//               undefined, r0 always wins contention and there is no
//               grant-history register.
//
// Ports:
//   clk                 in   single clock, rising edge
//   reset               in   synchronous, active-high
//   r0_valid / r1_valid in   write request
//   r0_ready / r1_ready out  request accepted this cycle (valid && ready)
//   r0_addr  / r1_addr  in   [4:0]  destination register
//   r0_data  / r1_data  in   [31:0] write data
//   rf_stall            in   register-file write port busy this cycle
//   rf_we               out  register-file write enable
//   rf_waddr            out  [4:0]  register-file write address
//   rf_wdata            out  [31:0] register-file write data
//   pend_mask           out  [31:0] one-hot mask of the held, unwritten reg
//   wr_count            out  [15:0] committed writes, saturating
// ---------------------------------------------------------------------------
module regfile_write_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [4:0]  r0_addr,
  input  logic [31:0] r0_data,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [4:0]  r1_addr,
  input  logic [31:0] r1_data,
  input  logic        rf_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask,
  output logic [15:0] wr_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  hold_state_t r_state;
  logic [4:0]  r_hold_addr;
  logic [31:0] r_hold_data;
  logic [15:0] r_wr_count;

  logic        w_hold_valid;
  logic        w_slot_free;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_load;
  logic [4:0]  w_load_addr;
  logic [31:0] w_load_data;
  logic        w_rf_we;

  assign w_hold_valid = (r_state == FULL);

  // The slot can take a new request when it is empty, or when its current
  // occupant is being written this cycle.
  assign w_slot_free = !w_hold_valid || !rf_stall;

`ifdef RR_ARB_EN
  // Holds the requester favoured on the next contention.  This is the
  // requester that was NOT granted most recently.  The reset value 0
  // favours r0.
  logic r_last_grant;

  assign w_grant0 = !reset && w_slot_free && r0_valid && (!r1_valid || !r_last_grant);
  assign w_grant1 = !reset && w_slot_free && r1_valid && (!r0_valid ||  r_last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b0;
    end else if (w_grant0) begin
      r_last_grant <= 1'b1;
    end else if (w_grant1) begin
      r_last_grant <= 1'b0;
    end
  end
`else
  assign w_grant0 = !reset && w_slot_free && r0_valid;
  assign w_grant1 = !reset && w_slot_free && r1_valid && !r0_valid;
`endif

  // A request to register 0 is granted, but the entry is not loaded with it.
  assign w_load      = (w_grant0 && (r0_addr != 5'd0)) ||
                       (w_grant1 && (r1_addr != 5'd0));
  assign w_load_addr = w_grant0 ? r0_addr : r1_addr;
  assign w_load_data = w_grant0 ? r0_data : r1_data;

  // Gating with reset drops an entry that is held when reset is applied, so
  // that entry is never written.
  assign w_rf_we = w_hold_valid && !rf_stall && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_hold_addr <= 5'd0;
      r_hold_data <= 32'd0;
      r_wr_count  <= 16'd0;
    end else begin
      if (w_rf_we && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      // A load takes priority over a drain.  This gives back-to-back refill
      // of the slot that is being written this cycle.
      if (w_load) begin
        r_state     <= FULL;
        r_hold_addr <= w_load_addr;
        r_hold_data <= w_load_data;
      end else if (w_rf_we) begin
        r_state <= EMPTY;
      end
    end
  end

  assign r0_ready  = w_grant0;
  assign r1_ready  = w_grant1;
  assign rf_we     = w_rf_we;
  assign rf_waddr  = r_hold_addr;
  assign rf_wdata  = r_hold_data;
  assign pend_mask = w_hold_valid ? (32'd1 << r_hold_addr) : 32'd0;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [4:0]  r0_addr, r1_addr, rf_waddr;
  logic [31:0] r0_data, r1_data, rf_wdata, pend_mask;
  logic        rf_stall, rf_we;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_addr  (r0_addr),
    .r0_data  (r0_data),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_addr  (r1_addr),
    .r1_data  (r1_data),
    .rf_stall (rf_stall),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .pend_mask(pend_mask),
    .wr_count (wr_count)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        stall;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_pend;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rs, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1, input logic st);
    reset = rs; r0_valid = v0; r0_addr = a0; r0_data = d0;
    r1_valid = v1; r1_addr = a1; r1_data = d1; rf_stall = st;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  function automatic vec_t mk(logic rst, logic v0, logic [4:0] a0, logic [31:0] d0,
                              logic v1, logic [4:0] a1, logic [31:0] d1, logic st,
                              logic r0, logic r1, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] pm, logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.stall = st; v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_we = we; v.e_waddr = wa;
    v.e_wdata = wd; v.e_pend = pm; v.e_cnt = cnt;
    return v;
  endfunction

  localparam logic [31:0] DA = 32'hA1A1_0001;
  localparam logic [31:0] DB = 32'hB2B2_0002;

  // behavioural reference state for random stimulus
  ent_t mq[$];
  int   m_cnt;
  int   m_prefer;

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cyc();
    cyc();

    // ---------------- table-driven sequence ----------------
    //            rst v0 a0    d0          v1 a1     d1            st  rdy0 rdy1 we waddr wdata pend cnt
    vecs.push_back(mk(1, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  0, 0, 0, 5'd0, 32'd0, 32'd0, 16'd0));
`ifdef RR_ARB_EN
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  1, 0, 0, 5'd0, 32'd0, 32'd0, 16'd0));
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  0, 1, 1, 5'd1, DA,    32'h2, 16'd0));
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  1, 0, 1, 5'd2, DB,    32'h4, 16'd1));
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  0, 1, 1, 5'd1, DA,    32'h2, 16'd2));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            0,  0, 0, 1, 5'd2, DB,    32'h4, 16'd3));
`else
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  1, 0, 0, 5'd0, 32'd0, 32'd0, 16'd0));
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  1, 0, 1, 5'd1, DA,    32'h2, 16'd0));
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  1, 0, 1, 5'd1, DA,    32'h2, 16'd1));
    vecs.push_back(mk(0, 1, 5'd1, DA,         1, 5'd2,  DB,           0,  1, 0, 1, 5'd1, DA,    32'h2, 16'd2));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            0,  0, 0, 1, 5'd1, DA,    32'h2, 16'd3));
`endif
    vecs.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0,           0,  1, 0, 0, 5'd0, 32'd0, 32'd0, 16'd4));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            0,  0, 0, 1, 5'd5, 32'hDEADBEEF, 32'h20, 16'd4));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            0,  0, 0, 0, 5'd0, 32'd0, 32'd0, 16'd5));
    vecs.push_back(mk(0, 1, 5'd0, 32'd1,      0, 5'd0,  0,            0,  1, 0, 0, 5'd0, 32'd0, 32'd0, 16'd5));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            0,  0, 0, 0, 5'd0, 32'd0, 32'd0, 16'd5));
    vecs.push_back(mk(0, 0, 5'd0, 0,          1, 5'd31, 32'hFFFF0001, 0,  0, 1, 0, 5'd0, 32'd0, 32'd0, 16'd5));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            1,  0, 0, 0, 5'd0, 32'd0, 32'h8000_0000, 16'd5));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            0,  0, 0, 1, 5'd31, 32'hFFFF0001, 32'h8000_0000, 16'd5));
    vecs.push_back(mk(0, 0, 5'd0, 0,          0, 5'd0,  0,            0,  0, 0, 0, 5'd0, 32'd0, 32'd0, 16'd6));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].stall);
      @(negedge clk);
      $display("vec %0d: rst=%0b v0=%0b a0=%0d v1=%0b a1=%0d st=%0b -> rdy=%0b%0b we=%0b wa=%0d wd=%h pm=%h cnt=%0d",
               i, reset, r0_valid, r0_addr, r1_valid, r1_addr, rf_stall,
               r0_ready, r1_ready, rf_we, rf_waddr, rf_wdata, pend_mask, wr_count);
      chk($sformatf("vec%0d_r0_ready", i), 32'(r0_ready), 32'(vecs[i].e_rdy0));
      chk($sformatf("vec%0d_r1_ready", i), 32'(r1_ready), 32'(vecs[i].e_rdy1));
      chk($sformatf("vec%0d_rf_we", i),    32'(rf_we),    32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata,      vecs[i].e_wdata);
      end
      chk($sformatf("vec%0d_pend_mask", i), pend_mask,     vecs[i].e_pend);
      chk($sformatf("vec%0d_wr_count", i),  32'(wr_count), 32'(vecs[i].e_cnt));
      cyc();
    end

    // ---------------- stall hold with r1 waiting ----------------
    do_reset();
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("stall_acc_r0_ready", 32'(r0_ready), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("stall cycle %0d: we=%0b r1_ready=%0b pm=%h", k, rf_we, r1_ready, pend_mask);
      chk($sformatf("stall%0d_rf_we", k),    32'(rf_we),    32'd0);
      chk($sformatf("stall%0d_r1_ready", k), 32'(r1_ready), 32'd0);
      chk($sformatf("stall%0d_pend", k),     pend_mask,     32'h8);
      cyc();
    end
    rf_stall = 1'b0;
    @(negedge clk);
    $display("stall release: we=%0b wa=%0d wd=%h r1_ready=%0b", rf_we, rf_waddr, rf_wdata, r1_ready);
    chk("release_rf_we",    32'(rf_we),    32'd1);
    chk("release_rf_waddr", 32'(rf_waddr), 32'd3);
    chk("release_rf_wdata", rf_wdata,      32'h33);
    chk("release_r1_ready", 32'(r1_ready), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("r1_write_we",    32'(rf_we),    32'd1);
    chk("r1_write_waddr", 32'(rf_waddr), 32'd4);
    chk("r1_write_wdata", rf_wdata,      32'h44);
    chk("r1_write_pend",  pend_mask,     32'h10);
    cyc();
    @(negedge clk);
    chk("stall_seq_count", 32'(wr_count), 32'd2);

    // ---------------- reset drops the held entry ----------------
    cyc();
    drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("rstdrop_acc_ready", 32'(r0_ready), 32'd1);
    cyc();
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0);
    @(negedge clk);
    $display("reset with entry held: we=%0b rdy=%0b%0b", rf_we, r0_ready, r1_ready);
    chk("rstdrop_we_in_reset", 32'(rf_we),    32'd0);
    chk("rstdrop_r0_ready",    32'(r0_ready), 32'd0);
    chk("rstdrop_r1_ready",    32'(r1_ready), 32'd0);
    cyc();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rstdrop_we_after%0d", k), 32'(rf_we),    32'd0);
      chk($sformatf("rstdrop_pend%0d", k),     pend_mask,     32'd0);
      chk($sformatf("rstdrop_cnt%0d", k),      32'(wr_count), 32'd0);
      cyc();
    end

    // ---------------- randomized against reference model ----------------
    do_reset();
    mq.delete();
    m_cnt = 0;
    m_prefer = 0;
    for (int n = 0; n < 3000; n++) begin
      logic rs, v0, v1, st, e_we, free, e_r0, e_r1;
      logic [4:0]  a0, a1;
      logic [31:0] d0, d1, e_pend;
      int g;
      rs = ($urandom_range(0, 99) < 2);
      v0 = $urandom_range(0, 1) == 1;
      v1 = $urandom_range(0, 1) == 1;
      st = ($urandom_range(0, 3) == 0);
      a0 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      d0 = $urandom;
      d1 = $urandom;
      drive(rs, v0, a0, d0, v1, a1, d1, st);

      free = (mq.size() == 0) || !st;
      e_we = !rs && (mq.size() != 0) && !st;
      g = -1;
      if (!rs && free) begin
        if (v0 && v1) g = m_prefer;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
      end
      e_r0 = (g == 0);
      e_r1 = (g == 1);
      e_pend = (mq.size() != 0) ? (32'd1 << mq[0].a) : 32'd0;

      @(negedge clk);
      chk("rnd_r0_ready", 32'(r0_ready), 32'(e_r0));
      chk("rnd_r1_ready", 32'(r1_ready), 32'(e_r1));
      chk("rnd_rf_we",    32'(rf_we),    32'(e_we));
      if (e_we) begin
        chk("rnd_rf_waddr", 32'(rf_waddr), 32'(mq[0].a));
        chk("rnd_rf_wdata", rf_wdata,      mq[0].d);
      end
      chk("rnd_pend_mask", pend_mask,     e_pend);
      chk("rnd_wr_count",  32'(wr_count), 32'(m_cnt));
      cyc();

      if (rs) begin
        mq.delete();
        m_cnt = 0;
        m_prefer = 0;
      end else begin
        if (e_we) begin
          if (m_cnt < 65535) m_cnt++;
          mq.delete(0);
        end
        if (g >= 0) begin
          ent_t e;
          e.a = (g == 0) ? a0 : a1;
          e.d = (g == 0) ? d0 : d1;
          if (e.a != 5'd0) mq.push_back(e);
`ifdef RR_ARB_EN
          m_prefer = 1 - g;
`endif
        end
      end
    end
    $display("random phase: 3000 cycles done");

    // ---------------- wr_count saturation ----------------
    do_reset();
    drive(1'b0, 1'b1, 5'd1, 32'h5A5A_5A5A, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i <= 65538; i++) begin
      @(negedge clk);
      if (i == 65535) chk("sat_count_65534", 32'(wr_count), 32'd65534);
      if (i == 65536) chk("sat_count_max",   32'(wr_count), 32'hFFFF);
      if (i == 65538) begin
        chk("sat_count_hold", 32'(wr_count), 32'hFFFF);
        chk("sat_we_active",  32'(rf_we),    32'd1);
      end
      cyc();
    end
    $display("saturation phase: wr_count=%0d", wr_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
